// File: rtl/sbox_scheduler_if.sv
// Request/response channels between the two requesters, the scheduler and the
// shared SubBytes unit.
interface sbox_scheduler_if;
  logic         a_valid;
  logic         a_ready;
  logic [127:0] a_data;
  logic         a_rsp_valid;
  logic         a_rsp_ready;
  logic [127:0] a_rsp_data;
  logic         b_valid;
  logic         b_ready;
  logic [31:0]  b_data;
  logic         b_rsp_valid;
  logic         b_rsp_ready;
  logic [31:0]  b_rsp_data;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic         busy;

  modport slave (
    input  a_valid, a_data, a_rsp_ready,
    input  b_valid, b_data, b_rsp_ready,
    input  sb_out,
    output a_ready, a_rsp_valid, a_rsp_data,
    output b_ready, b_rsp_valid, b_rsp_data,
    output sb_in, busy
  );

  modport master (
    output a_valid, a_data, a_rsp_ready,
    output b_valid, b_data, b_rsp_ready,
    output sb_out,
    input  a_ready, a_rsp_valid, a_rsp_data,
    input  b_ready, b_rsp_valid, b_rsp_data,
    input  sb_in, busy
  );
endinterface

// File: rtl/sbox_scheduler.sv
// Round-robin sharing of one registered SubBytes unit between the round datapath (A)
// and key expansion (B), with per-requester result registers.
module sbox_scheduler #(
  parameter int unsigned SBOX_LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  input logic              clear,
  sbox_scheduler_if.slave  bus
);

  typedef enum logic {IdA = 1'b0, IdB = 1'b1} req_id_e;

  localparam int unsigned Depth = SBOX_LATENCY + 1;

  logic             owned_a_q, owned_a_d, owned_b_q, owned_b_d;
  req_id_e          last_grant_q, last_grant_d;
  logic [Depth-1:0] trk_v_q, trk_v_d;
  logic [Depth-1:0] trk_id_q, trk_id_d;  // 1 = B
  logic [127:0]     sb_in_q, sb_in_d;
  logic             a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
  logic [127:0]     a_rsp_data_q, a_rsp_data_d;
  logic [31:0]      b_rsp_data_q, b_rsp_data_d;

  logic elig_a, elig_b, grant_a, grant_b, hs_a, hs_b, tail_v, tail_b;

  always_comb begin
    // No accept during the flush cycle.
    elig_a  = bus.a_valid && !owned_a_q && !clear;
    elig_b  = bus.b_valid && !owned_b_q && !clear;
    grant_a = elig_a && (!elig_b || (last_grant_q == IdB));
    grant_b = elig_b && !grant_a;
    hs_a    = a_rsp_valid_q && bus.a_rsp_ready;
    hs_b    = b_rsp_valid_q && bus.b_rsp_ready;
    tail_v  = trk_v_q[Depth-1];
    tail_b  = trk_id_q[Depth-1];
  end

  always_comb begin
    owned_a_d     = owned_a_q;
    owned_b_d     = owned_b_q;
    last_grant_d  = last_grant_q;
    trk_v_d       = {trk_v_q[Depth-2:0], grant_a || grant_b};
    trk_id_d      = {trk_id_q[Depth-2:0], grant_b};
    sb_in_d       = sb_in_q;
    a_rsp_valid_d = a_rsp_valid_q;
    b_rsp_valid_d = b_rsp_valid_q;
    a_rsp_data_d  = a_rsp_data_q;
    b_rsp_data_d  = b_rsp_data_q;

    if (grant_a) begin
      sb_in_d      = bus.a_data;
      last_grant_d = IdA;
    end else if (grant_b) begin
      sb_in_d      = {96'h0, bus.b_data};
      last_grant_d = IdB;
    end

    if (grant_a)   owned_a_d = 1'b1;
    else if (hs_a) owned_a_d = 1'b0;
    if (grant_b)   owned_b_d = 1'b1;
    else if (hs_b) owned_b_d = 1'b0;

    // owned_x blocks reissue, so the tail never lands on a full result register.
    if (tail_v && !tail_b) begin
      a_rsp_valid_d = 1'b1;
      a_rsp_data_d  = bus.sb_out;
    end else if (hs_a) begin
      a_rsp_valid_d = 1'b0;
    end
    if (tail_v && tail_b) begin
      b_rsp_valid_d = 1'b1;
      b_rsp_data_d  = bus.sb_out[31:0];
    end else if (hs_b) begin
      b_rsp_valid_d = 1'b0;
    end

    if (clear) begin
      owned_a_d     = 1'b0;
      owned_b_d     = 1'b0;
      last_grant_d  = IdA;
      trk_v_d       = '0;
      a_rsp_valid_d = 1'b0;
      b_rsp_valid_d = 1'b0;
      a_rsp_data_d  = a_rsp_data_q;
      b_rsp_data_d  = b_rsp_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owned_a_q     <= 1'b0;
      owned_b_q     <= 1'b0;
      last_grant_q  <= IdA;
      trk_v_q       <= '0;
      trk_id_q      <= '0;
      sb_in_q       <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
    end else begin
      owned_a_q     <= owned_a_d;
      owned_b_q     <= owned_b_d;
      last_grant_q  <= last_grant_d;
      trk_v_q       <= trk_v_d;
      trk_id_q      <= trk_id_d;
      sb_in_q       <= sb_in_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_data_q  <= b_rsp_data_d;
    end
  end

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.sb_in       = sb_in_q;
  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.a_rsp_data  = a_rsp_data_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.b_rsp_data  = b_rsp_data_q;
  assign bus.busy        = owned_a_q || owned_b_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Bench for sbox_scheduler: a per-cycle vector table plus a backpressure sequence,
// with a registered AES S-box model behind sb_in/sb_out.
module tb_sbox_scheduler;

  localparam logic [127:0] DA  = {4{32'h00010203}};
  localparam logic [127:0] SA  = {4{32'h637C777B}};
  localparam logic [127:0] DA2 = {4{32'h53FF0001}};
  localparam logic [127:0] SA2 = {4{32'hED16637C}};
  localparam logic [31:0]  DB  = 32'h53FF0001;
  localparam logic [31:0]  SB  = 32'hED16637C;
  localparam logic [31:0]  DB2 = 32'h00010203;
  localparam logic [31:0]  SB2 = 32'h637C777B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sbox_scheduler_if bus ();

  sbox_scheduler #(.SBOX_LATENCY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox(s[i*8 +: 8]);
    return r;
  endfunction

  // Shared SubBytes unit: one register stage.
  always_ff @(posedge clk) bus.sb_out <= sub_bytes(bus.sb_in);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         av;
    logic [127:0] ad;
    logic         bv;
    logic [31:0]  bd;
    logic         arr;
    logic         brr;
    logic         clr;
    logic         ar;
    logic         br;
    logic         arv;
    logic [127:0] ard;
    logic         brv;
    logic [31:0]  brd;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic av, input logic [127:0] ad, input logic bv,
                              input logic [31:0] bd, input logic clr, input logic ar,
                              input logic br, input logic arv, input logic [127:0] ard,
                              input logic brv, input logic [31:0] brd, input logic busy);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.arr = 1'b1; v.brr = 1'b1; v.clr = clr;
    v.ar = ar; v.br = br; v.arv = arv; v.ard = ard; v.brv = brv; v.brd = brd; v.busy = busy;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [127:0] ad, input logic bv,
                       input logic [31:0] bd, input logic arr, input logic brr,
                       input logic clr);
    bus.a_valid = av; bus.a_data = ad; bus.b_valid = bv; bus.b_data = bd;
    bus.a_rsp_ready = arr; bus.b_rsp_ready = brr; clear = clr;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Single A; tie (B first); single B; tie (A first); flush; fresh A.
    tbl.push_back(mk(1, DA,  0, 0,   0, 1, 0, 0, 0,   0, 0,   0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, 0,   0, 0,   1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, 0,   0, 0,   1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 1, SA,  0, 0,   1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  0, 0,   0));
    tbl.push_back(mk(1, DA2, 1, DB,  0, 0, 1, 0, SA,  0, 0,   0));
    tbl.push_back(mk(1, DA2, 1, DB,  0, 1, 0, 0, SA,  0, 0,   1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  0, 0,   1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  1, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 1, SA2, 0, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA2, 0, SB,  0));
    tbl.push_back(mk(0, 0,   1, DB2, 0, 0, 1, 0, SA2, 0, SB,  0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA2, 0, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA2, 0, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA2, 1, SB2, 1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA2, 0, SB2, 0));
    tbl.push_back(mk(1, DA,  1, DB,  0, 1, 0, 0, SA2, 0, SB2, 0));
    tbl.push_back(mk(1, DA,  1, DB,  0, 0, 1, 0, SA2, 0, SB2, 1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA2, 0, SB2, 1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 1, SA,  0, SB2, 1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  1, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  0, SB,  0));
    tbl.push_back(mk(1, DA2, 0, 0,   0, 1, 0, 0, SA,  0, SB,  0));
    tbl.push_back(mk(1, DA2, 0, 0,   1, 0, 0, 0, SA,  0, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  0, SB,  0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  0, SB,  0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  0, SB,  0));
    tbl.push_back(mk(1, DA2, 0, 0,   0, 1, 0, 0, SA,  0, SB,  0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  0, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA,  0, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 1, SA2, 0, SB,  1));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0, 0, 0, SA2, 0, SB,  0));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d a_ready", i), bus.a_ready, 0);
      chk($sformatf("idle%0d b_ready", i), bus.b_ready, 0);
      chk($sformatf("idle%0d a_rsp_valid", i), bus.a_rsp_valid, 0);
      chk($sformatf("idle%0d b_rsp_valid", i), bus.b_rsp_valid, 0);
      chk($sformatf("idle%0d a_rsp_data", i), bus.a_rsp_data, 0);
      chk($sformatf("idle%0d b_rsp_data", i), bus.b_rsp_data, 0);
      chk($sformatf("idle%0d sb_in", i), bus.sb_in, 0);
      chk($sformatf("idle%0d busy", i), bus.busy, 0);
    end

    foreach (tbl[i]) begin
      @(posedge clk);
      #1 drive(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].arr, tbl[i].brr,
               tbl[i].clr);
      @(negedge clk);
      chk($sformatf("row%0d a_ready", i), bus.a_ready, tbl[i].ar);
      chk($sformatf("row%0d b_ready", i), bus.b_ready, tbl[i].br);
      chk($sformatf("row%0d a_rsp_valid", i), bus.a_rsp_valid, tbl[i].arv);
      chk($sformatf("row%0d a_rsp_data", i), bus.a_rsp_data, tbl[i].ard);
      chk($sformatf("row%0d b_rsp_valid", i), bus.b_rsp_valid, tbl[i].brv);
      chk($sformatf("row%0d b_rsp_data", i), bus.b_rsp_data, tbl[i].brd);
      chk($sformatf("row%0d busy", i), bus.busy, tbl[i].busy);
    end

    // A held off for 8 cycles after its result; B keeps cycling every 4 cycles.
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1 drive(1'b1, DA, 1'b1, DB, (k >= 12), 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("bp%0d a_ready", k), bus.a_ready, (k == 1 || k == 13));
      chk($sformatf("bp%0d b_ready", k), bus.b_ready, (k % 4 == 0));
      chk($sformatf("bp%0d a_rsp_valid", k), bus.a_rsp_valid, (k >= 4 && k <= 12));
      chk($sformatf("bp%0d b_rsp_valid", k), bus.b_rsp_valid, (k % 4 == 3));
      if (k >= 4 && k <= 12) chk($sformatf("bp%0d a_rsp_data", k), bus.a_rsp_data, SA);
      if (k == 11) chk("bp11 b_rsp_data", bus.b_rsp_data, SB);
    end

    @(posedge clk);
    #1 drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("drain busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_scheduler.md
# sbox_scheduler

Shares one 128-bit SubBytes unit (sixteen registered S-boxes) between two requesters in the pipelined AES core: the round datapath (full 128-bit state) and the key-expansion unit (32-bit SubWord). It arbitrates round-robin, drives the shared unit's input, tracks each in-flight lookup, and returns results to the right requester through per-requester result registers with valid/ready handshakes. This replaces a second S-box bank in the key schedule.

## Interface

- SBOX_LATENCY, 1: cycles from a change on sb_in to the matching value on sb_out (registered S-box = 1); legal range 1–4.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: drops in-flight and held results.
- a_valid / a_ready  in / out  1 / 1  round-datapath request handshake.
- a_data  in  128  state to substitute.
- a_rsp_valid / a_rsp_ready  out / in  1 / 1  round-datapath response handshake.
- a_rsp_data  out  128  SubBytes(a_data).
- b_valid / b_ready  in / out  1 / 1  key-expansion request handshake.
- b_data  in  32  word to substitute.
- b_rsp_valid / b_rsp_ready  out / in  1 / 1  key-expansion response handshake.
- b_rsp_data  out  32  SubWord(b_data).
- sb_in  out  128  registered operand to the shared SubBytes unit.
- sb_out  in  128  result from the shared SubBytes unit.
- busy  out  1  any lookup in flight or any result held.

## Operation

- Per-requester flag owned_x: set on request accept, cleared on response handshake (x_rsp_valid && x_rsp_ready). One outstanding transaction per requester.
- Eligible: elig_x = x_valid && !owned_x. At most one grant per cycle.
- Arbitration: only one eligible wins. If both are eligible, the requester not granted last wins. Pointer last_grant updates on every grant. It resets to A, so B wins the first tie.
- x_ready = elig_x && grant_x. Ready is combinational from valid; valid must not depend on ready.
- Accept of A: sb_in <= a_data. Accept of B: sb_in <= {96'h0, b_data}. No accept: sb_in holds its value.
- In-flight tracker: shift register, depth SBOX_LATENCY+1, entries {valid, id}; an entry is pushed on each accept.
- Tail entry valid:
  - id A: a_rsp_data <= sb_out, set a_rsp_valid.
  - id B: b_rsp_data <= sb_out[31:0], set b_rsp_valid.
- A result register never receives a second result while full, because owned_x blocks reissue.
- x_rsp_valid and x_rsp_data hold until the handshake. owned_x clears in the handshake cycle, so re-request is eligible the next cycle.
- clear: zeroes the tracker, owned_a/b, a/b_rsp_valid and last_grant(=A). No accept in the clear cycle. Data registers and sb_in keep their values.
- busy = owned_a || owned_b.

## Timing

- Reset values: a_ready=b_ready=0 while no valid; a_rsp_valid=b_rsp_valid=0; a_rsp_data=0; b_rsp_data=0; sb_in=0; busy=0; tracker empty; last_grant=A.
- Accept in cycle t: sb_in valid from t+1, sb_out from t+1+SBOX_LATENCY. x_rsp_valid rises at t+2+SBOX_LATENCY (default t+3).
- Back-to-back throughput:
  - Two requesters interleaved: one accept per cycle.
  - Single requester with rsp_ready tied high: one accept per SBOX_LATENCY+3 cycles (default 4).
- Simultaneous response handshake and new valid on the same requester: the handshake clears owned; the new request is eligible the next cycle, not the same cycle.
- Reset or clear mid-lookup: the in-flight result is discarded. It never appears on x_rsp_valid, even though sb_out later shows it.

## Test plan

- Reset then idle: after rst released, all valids/readys 0, sb_in=0, busy=0 for 10 cycles.
- Single A, SBOX_LATENCY=1, a_rsp_ready=1: a_data=128'h00010203 repeated ×4, accept at t -> a_rsp_valid at t+3, a_rsp_data=128'h637C777B repeated ×4, one cycle high.
- Single B: b_data=32'h53FF0001 -> b_rsp_data=32'hED16637C at accept+3. a_rsp_valid stays 0.
- Tie: a_valid and b_valid both rise at t -> B accepted at t, A at t+1. b_rsp_valid at t+3, a_rsp_valid at t+4; next tie afterwards is granted to A.
- Backpressure: a_rsp_ready=0 for 8 cycles after the result. a_rsp_data stable and a_ready=0 while a_valid held. B continues to be served every 4 cycles. A accepts the cycle after the first handshake.
- Flush: assert clear the cycle after an A accept -> a_rsp_valid never rises and busy=0 the next cycle. A fresh request completes with correct data 3 cycles after its accept.
